// File: rtl/xbus_arb_pkg.sv
// Shared definitions for the xbus two-master arbiter: widths, starvation defaults
// and the grant encoding with its priority rule.
package xbus_arb_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned ARB_STARVE_LIM = 15;
    localparam int unsigned ARB_CW         = 4;

    typedef enum logic [1:0] {
        ARB_GNT_NONE = 2'd0,
        ARB_GNT_C    = 2'd1,
        ARB_GNT_D    = 2'd2
    } arb_gnt_e;

    // M0 has priority unless M1 is starved; M1 otherwise takes idle controller cycles.
    function automatic arb_gnt_e arb_grant(input logic c_sel, input logic d_req,
                                           input logic starved);
        arb_gnt_e g;
        g = ARB_GNT_NONE;
        if (d_req && (!c_sel || starved)) begin
            g = ARB_GNT_D;
        end else if (c_sel) begin
            g = ARB_GNT_C;
        end
        return g;
    endfunction

endpackage

// File: rtl/xbus_arb_if.sv
// Signal bundle between the two bus masters (c_*, d_*), the arbiter and the merged
// decoder-side bus (b_*). The arbiter uses the slave view, the environment the master view.
interface xbus_arb_if
    import xbus_arb_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned DW = DATA_W
);
    logic          c_sel;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data_wr;
    logic [DW-1:0] c_data_rd;
    logic          c_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data_wr;
    logic          d_ack;
    logic [DW-1:0] d_data_rd;
    logic          d_rvalid;

    logic          b_sel;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data_wr;
    logic [DW-1:0] b_data_rd;

    modport slave (
        input  c_sel, c_we, c_addr, c_data_wr,
        output c_data_rd, c_stall,
        input  d_req, d_we, d_addr, d_data_wr,
        output d_ack, d_data_rd, d_rvalid,
        output b_sel, b_we, b_addr, b_data_wr,
        input  b_data_rd
    );

    modport master (
        output c_sel, c_we, c_addr, c_data_wr,
        input  c_data_rd, c_stall,
        output d_req, d_we, d_addr, d_data_wr,
        input  d_ack, d_data_rd, d_rvalid,
        input  b_sel, b_we, b_addr, b_data_wr,
        output b_data_rd
    );

endinterface

// File: rtl/xbus_arb_starve.sv
// Starvation tracker for M1: counts ungranted request cycles and raises a
// registered starved flag once the count has reached its limit.
module xarb_starve #(
    parameter int unsigned LIM = 15,
    parameter int unsigned CW  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic starved
);

    localparam logic [CW-1:0] LIM_V = CW'(LIM);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            starved <= 1'b0;
        end else begin
            if (!req || ack) begin
                cnt <= '0;
            end else if (cnt != LIM_V) begin
                cnt <= cnt + CW'(1);
            end
            // cnt is still saturated on the forced-grant cycle, so ack must drop starved
            starved <= req && !ack && (cnt == LIM_V);
        end
    end

endmodule

// File: rtl/xbus_arb.sv
// Two-master arbiter merging the xctrl controller (M0, priority) and a DMA/bridge
// requester (M1) onto the single-cycle decoder bus, with starvation relief for M1.
module xbus_arb
    import xbus_arb_pkg::*;
#(
    parameter int unsigned AW         = ADDR_W,
    parameter int unsigned DW         = DATA_W,
    parameter int unsigned STARVE_LIM = ARB_STARVE_LIM,
    parameter int unsigned CW         = ARB_CW
) (
    input  logic       clk,
    input  logic       rst,
    xbus_arb_if.slave  bus
);

    arb_gnt_e      gnt;
    logic          starved;
    logic          d_ack;
    logic          sel;
    logic          we;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;

    xarb_starve #(
        .LIM (STARVE_LIM),
        .CW  (CW)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.d_req),
        .ack     (d_ack),
        .starved (starved)
    );

    always_comb begin
        gnt       = arb_grant(bus.c_sel, bus.d_req, starved);
        sel       = 1'b0;
        we        = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        unique case (gnt)
            ARB_GNT_D: begin
                sel       = 1'b1;
                we        = bus.d_we;
                addr_mux  = bus.d_addr;
                wdata_mux = bus.d_data_wr;
            end
            ARB_GNT_C: begin
                sel       = 1'b1;
                we        = bus.c_we;
                addr_mux  = bus.c_addr;
                wdata_mux = bus.c_data_wr;
            end
            default: ;
        endcase
    end

    assign d_ack         = (gnt == ARB_GNT_D);
    assign bus.d_ack     = d_ack;
    assign bus.c_stall   = bus.c_sel && d_ack;
    assign bus.c_data_rd = (gnt == ARB_GNT_C) ? bus.b_data_rd : '0;
    assign bus.b_sel     = sel;
    assign bus.b_we      = we;
    assign bus.b_addr    = addr_mux;
    assign bus.b_data_wr = wdata_mux;
    assign bus.d_data_rd = rdata_q;
    assign bus.d_rvalid  = rvalid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (d_ack && !bus.d_we) begin
            rdata_q  <= bus.b_data_rd;
            rvalid_q <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
        end
    end

    a_d_req_held: assert property (@(posedge clk) disable iff (!rst)
        (bus.d_req && !d_ack) |=> bus.d_req);

    a_d_stable: assert property (@(posedge clk) disable iff (!rst)
        (bus.d_req && !d_ack) |=> $stable({bus.d_we, bus.d_addr, bus.d_data_wr}));

    a_c_stable: assert property (@(posedge clk) disable iff (!rst)
        bus.c_stall |=> $stable({bus.c_sel, bus.c_we, bus.c_addr, bus.c_data_wr}));

endmodule

// File: tb/tb_xbus_arb.sv
// Bench for xbus_arb: directed scenarios plus randomized traffic checked against a
// wait-time model of the arbitration rules.
module tb_xbus_arb;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned LIM = 15;
    localparam int unsigned BW  = 2 + AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    xbus_arb_if #(.AW(AW), .DW(DW)) bus ();

    xbus_arb #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_LIM (LIM),
        .CW         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.c_sel = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_data_wr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_data_wr = '0;
        bus.b_data_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.c_sel = 1'b1; bus.c_addr = 16'h0022;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0077; bus.d_data_wr = 16'h0099;
        bus.b_data_rd = 16'h0BEE;
        #3;
        total++;
        if (bus.d_rvalid !== 1'b0 || bus.d_data_rd !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rdata: rvalid=%b rdata=%h required 0/0000", bus.d_rvalid, bus.d_data_rd);
        end
        total++;
        if (bus.d_ack !== 1'b0 || bus.c_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant: ack=%b stall=%b required 0/0", bus.d_ack, bus.c_stall);
        end
        total++;
        if (bus.b_sel !== 1'b1) begin
            bad++;
            $display("FAIL reset_bsel: b_sel=%b required 1", bus.b_sel);
        end
        next_cycle();
        rst = 1'b1;
        #3;
        total++;
        if (bus.b_addr !== 16'h0022 || bus.d_ack !== 1'b0 || bus.c_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_owner: b_addr=%h ack=%b stall=%b required 0022/0/0",
                     bus.b_addr, bus.d_ack, bus.c_stall);
        end
        next_cycle();
        bus.c_sel = 1'b0;
        #3;
        total++;
        if (bus.d_ack !== 1'b1 || bus.b_addr !== 16'h0077) begin
            bad++;
            $display("FAIL reset_then_idle: ack=%b b_addr=%h required 1/0077", bus.d_ack, bus.b_addr);
        end
        next_cycle();
        bus.d_req = 1'b0;
    endtask

    task automatic test_idle_steal();
        next_cycle();
        bus.c_sel = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_data_wr = 16'h00A5;
        #3;
        total++;
        if (bus.d_ack !== 1'b1 || bus.c_stall !== 1'b0) begin
            bad++;
            $display("FAIL steal_ack: ack=%b stall=%b required 1/0", bus.d_ack, bus.c_stall);
        end
        total++;
        if ({bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr} !== {1'b1, 1'b1, 16'h0010, 16'h00A5}) begin
            bad++;
            $display("FAIL steal_bus: sel=%b we=%b addr=%h wd=%h required 1/1/0010/00A5",
                     bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr);
        end
        next_cycle();
        bus.d_req = 1'b0;
        #3;
        total++;
        if ({bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr, bus.d_rvalid} !== '0) begin
            bad++;
            $display("FAIL steal_idle: sel=%b we=%b addr=%h wd=%h rvalid=%b required all 0",
                     bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr, bus.d_rvalid);
        end
    endtask

    task automatic test_read_return();
        next_cycle();
        bus.c_sel = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0040; bus.d_data_wr = 16'h0000;
        bus.b_data_rd = 16'h1234;
        #3;
        total++;
        if (bus.d_ack !== 1'b1 || bus.b_sel !== 1'b1 || bus.b_we !== 1'b0) begin
            bad++;
            $display("FAIL read_ack: ack=%b sel=%b we=%b required 1/1/0", bus.d_ack, bus.b_sel, bus.b_we);
        end
        next_cycle();
        bus.d_req = 1'b0;
        bus.b_data_rd = 16'hFFFF;
        #3;
        total++;
        if (bus.d_rvalid !== 1'b1 || bus.d_data_rd !== 16'h1234) begin
            bad++;
            $display("FAIL read_return: rvalid=%b rdata=%h required 1/1234", bus.d_rvalid, bus.d_data_rd);
        end
        next_cycle();
        #3;
        total++;
        if (bus.d_rvalid !== 1'b0 || bus.d_data_rd !== 16'h1234) begin
            bad++;
            $display("FAIL read_hold: rvalid=%b rdata=%h required 0/1234", bus.d_rvalid, bus.d_data_rd);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] rd;
        next_cycle();
        bus.c_sel = 1'b1; bus.c_we = 1'b1; bus.c_addr = 16'h0033; bus.c_data_wr = 16'h0C0C;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0044; bus.d_data_wr = 16'h0D0D;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) next_cycle();
            rd = 16'h5A00 + DW'(k);
            bus.b_data_rd = rd;
            #3;
            total++;
            if ({bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr} !== {1'b1, 1'b1, 16'h0033, 16'h0C0C}) begin
                bad++;
                $display("FAIL contend_bus[%0d]: addr=%h wd=%h required 0033/0C0C", k, bus.b_addr, bus.b_data_wr);
            end
            total++;
            if (bus.c_data_rd !== rd || bus.d_ack !== 1'b0 || bus.c_stall !== 1'b0) begin
                bad++;
                $display("FAIL contend_ctrl[%0d]: crd=%h ack=%b stall=%b required %h/0/0",
                         k, bus.c_data_rd, bus.d_ack, bus.c_stall, rd);
            end
        end
        next_cycle();
        bus.c_sel = 1'b0;
        #3;
        total++;
        if (bus.d_ack !== 1'b1 || bus.b_addr !== 16'h0044 || bus.c_data_rd !== 16'h0000) begin
            bad++;
            $display("FAIL contend_release: ack=%b addr=%h crd=%h required 1/0044/0000",
                     bus.d_ack, bus.b_addr, bus.c_data_rd);
        end
        next_cycle();
        bus.d_req = 1'b0;
    endtask

    task automatic test_starvation();
        logic exp_g;
        next_cycle();
        bus.c_sel = 1'b1; bus.c_we = 1'b0; bus.c_addr = 16'h0030; bus.c_data_wr = 16'h0000;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0055; bus.d_data_wr = 16'h0066;
        for (int k = 1; k <= int'(LIM) + 3; k++) begin
            if (k > 1) next_cycle();
            if (k == int'(LIM) + 3) bus.d_req = 1'b0;
            #3;
            exp_g = (k == int'(LIM) + 2);
            total++;
            if (bus.d_ack !== exp_g || bus.c_stall !== exp_g) begin
                bad++;
                $display("FAIL starve_grant[%0d]: ack=%b stall=%b required %b/%b",
                         k, bus.d_ack, bus.c_stall, exp_g, exp_g);
            end
            total++;
            if (bus.b_addr !== (exp_g ? 16'h0055 : 16'h0030)) begin
                bad++;
                $display("FAIL starve_addr[%0d]: b_addr=%h required %h", k, bus.b_addr,
                         exp_g ? 16'h0055 : 16'h0030);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        bus.c_sel = 1'b1; bus.c_we = 1'b0; bus.c_addr = 16'h0031;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0056;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) next_cycle();
            #3;
            total++;
            if (bus.d_ack !== 1'b0) begin
                bad++;
                $display("FAIL midwait_pre[%0d]: ack=%b required 0", k, bus.d_ack);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.d_ack !== 1'b0 || bus.c_stall !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midwait_reset: ack=%b stall=%b rvalid=%b required 0/0/0",
                     bus.d_ack, bus.c_stall, bus.d_rvalid);
        end
        next_cycle();
        rst = 1'b1;
        for (int k = 1; k <= int'(LIM) + 2; k++) begin
            if (k > 1) next_cycle();
            #3;
            total++;
            if (bus.d_ack !== (k == int'(LIM) + 2)) begin
                bad++;
                $display("FAIL midwait_restart[%0d]: ack=%b required %b", k, bus.d_ack, k == int'(LIM) + 2);
            end
        end
        next_cycle();
        bus.d_req = 1'b0;
        next_cycle();
        bus.c_sel = 1'b0;
    endtask

    // Model: M1 is granted when M0 is idle or after it has already waited LIM+1 cycles.
    task automatic test_random(input int n, input int pc);
        int unsigned   m_wait;
        logic          m_rv;
        logic [DW-1:0] m_rd;
        logic          p_gd, p_dreq, p_dwe;
        logic [DW-1:0] p_brd;
        logic          hold_c, hold_d, gd, gc;
        logic [BW-1:0] exp_bus;
        logic [DW-1:0] exp_crd;
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        m_wait = 0; m_rv = 1'b0; m_rd = '0;
        p_gd = 1'b0; p_dreq = 1'b0; p_dwe = 1'b0; p_brd = '0;
        hold_c = 1'b0; hold_d = 1'b0;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            if (p_gd && !p_dwe) begin
                m_rv = 1'b1;
                m_rd = p_brd;
            end else begin
                m_rv = 1'b0;
            end
            m_wait = (p_dreq && !p_gd) ? m_wait + 1 : 0;
            if (!hold_c) begin
                bus.c_sel     = ($urandom_range(0, 99) < pc);
                bus.c_we      = 1'($urandom_range(0, 1));
                bus.c_addr    = AW'($urandom);
                bus.c_data_wr = DW'($urandom);
            end
            if (!hold_d) begin
                bus.d_req     = ($urandom_range(0, 99) < 60);
                bus.d_we      = 1'($urandom_range(0, 1));
                bus.d_addr    = AW'($urandom);
                bus.d_data_wr = DW'($urandom);
            end
            bus.b_data_rd = DW'($urandom);
            #3;
            gd = bus.d_req && (!bus.c_sel || (m_wait > LIM));
            gc = bus.c_sel && !gd;
            if (gd) exp_bus = {1'b1, bus.d_we, bus.d_addr, bus.d_data_wr};
            else if (gc) exp_bus = {1'b1, bus.c_we, bus.c_addr, bus.c_data_wr};
            else exp_bus = '0;
            exp_crd = gc ? bus.b_data_rd : '0;
            total++;
            if (bus.d_ack !== gd || bus.c_stall !== (bus.c_sel && gd)) begin
                bad++;
                $display("FAIL rnd_grant[%0d]: ack=%b stall=%b required %b/%b (wait=%0d)",
                         i, bus.d_ack, bus.c_stall, gd, bus.c_sel && gd, m_wait);
            end
            total++;
            if ({bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr} !== exp_bus) begin
                bad++;
                $display("FAIL rnd_bus[%0d]: got=%h required %h", i,
                         {bus.b_sel, bus.b_we, bus.b_addr, bus.b_data_wr}, exp_bus);
            end
            total++;
            if (bus.c_data_rd !== exp_crd) begin
                bad++;
                $display("FAIL rnd_crd[%0d]: crd=%h required %h", i, bus.c_data_rd, exp_crd);
            end
            total++;
            if (bus.d_rvalid !== m_rv || bus.d_data_rd !== m_rd) begin
                bad++;
                $display("FAIL rnd_rret[%0d]: rvalid=%b rdata=%h required %b/%h",
                         i, bus.d_rvalid, bus.d_data_rd, m_rv, m_rd);
            end
            hold_c = bus.c_sel && gd;
            hold_d = bus.d_req && !gd;
            p_gd = gd; p_dreq = bus.d_req; p_dwe = bus.d_we; p_brd = bus.b_data_rd;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_idle_steal();
        test_read_return();
        test_contention();
        test_starvation();
        test_reset_mid_wait();
        test_random(800, 60);
        test_random(800, 97);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
